mem_regions: RTL
================

# mem_regions

Parametrised, region-mapped data memory for the MEM stage of the pipelined MIPS core. It supports byte, half and word accesses, a REQ/READY handshake with a configurable number of wait states, and reports alignment and access faults in place of silently returning undefined data. It sits behind the EX/MEM pipeline register and drives read data into the MEM/WB register. Memory contents are not reset.

## Interface

Parameters:
- TEXT_BASE, default 32'h0000_0000: byte address of first text word.
- TEXT_WORDS, default 256: text region depth, in words.
- DATA_BASE, default 32'h0000_1000: byte address of first data word.
- DATA_WORDS, default 256: data region depth, in words.
- STACK_TOP, default 32'h007F_FFFC: byte address of highest stack word; the stack grows down.
- STACK_WORDS, default 256: stack region depth, in words.
- WAIT, default 0: extra wait cycles per access, range 0..15.

Ports:
- CLK, in, 1: clock, rising edge.
- RST_N, in, 1: reset. Asynchronous, active-low.
- REQ, in, 1: access request.
- WE, in, 1: 1 = store, 0 = load.
- SIZE, in, 2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- UNS, in, 1: zero-extend loads (lbu/lhu) instead of sign-extending.
- A, in, 32: byte address.
- WD, in, 32: store data, right-justified.
- BUSY, out, 1: access in progress; REQ is ignored while BUSY=1.
- READY, out, 1: one-cycle pulse marking access completion. RD and FAULT are valid while READY=1.
- RD, out, 32: load data, extended to 32 bits.
- FAULT, out, 2: bit 0 = misaligned, bit 1 = access fault (unmapped address, or protected write).

## Operation

**Acceptance**
- A request is accepted on a rising edge where REQ=1 and BUSY=0.
- On acceptance, A, WD, WE, SIZE and UNS are latched.

**State machine**
- States: IDLE, WAITING, DONE.
- IDLE or DONE, with accept: go to WAITING, counter loaded with WAIT. If WAIT=0, go directly to DONE and perform the access.
- IDLE or DONE, without accept: go to IDLE.
- WAITING: the counter decrements each cycle. When it reaches 0, perform the access and go to DONE.
- Outputs by state: BUSY=1 only in WAITING; READY=1 only in DONE.
- Back-to-back requests are legal while in DONE.

**Region decode** (on the latched address)
- text: TEXT_BASE..TEXT_BASE+4*TEXT_WORDS-1
- data: DATA_BASE..DATA_BASE+4*DATA_WORDS-1
- stack: STACK_TOP-4*(STACK_WORDS-1)..STACK_TOP+3
- Word index = (A - region low bound) >> 2.
- Regions must not overlap; if they do, priority is stack, then data, then text.

**Alignment**
- Half access with A[0]=1 is misaligned: FAULT[0]=1.
- Word access with A[1:0]≠0 is misaligned: FAULT[0]=1.

**Byte lanes** (big-endian)
- A[1:0]=0 selects bits 31:24; A[1:0]=3 selects bits 7:0.
- Half with A[1]=0 selects bits 31:16.

**Store**
- Word store: the whole word is written.
- Byte or half store: WD[7:0] or WD[15:0] is merged into the selected lanes. Other lanes are preserved.
- The write is committed on the edge that enters DONE.

**Load**
- The selected lanes are shifted down to bit 0.
- They are sign-extended, or zero-extended if UNS=1.

**Faults**
- Any fault suppresses the write.
- On a fault, RD=0.
- Both FAULT bits can be set at once.
- A store gives RD=0.

## Timing

- Reset values (asserted asynchronously): state IDLE, BUSY=0, READY=0, RD=0, FAULT=0, counter 0.
- Latency: for a request accepted at edge k, the access happens at edge k+WAIT. READY=1 during the cycle after that edge.
- BUSY=1 in the WAIT cycles after edge k.
- Throughput: one access per WAIT+1 cycles.
- Reset mid-access: the access is abandoned, nothing is written, and no READY pulse follows.
- RD and FAULT hold their values after READY falls, until the next completion.

## Configuration

- Macro: MEM_TEXT_WP_EN.
- Defined: the text region is write-protected. A store hitting text sets FAULT[1]=1 and is not written; loads from text are unaffected.
- Undefined: text is writable like the other regions. FAULT[1] then flags unmapped addresses only.

## Test plan

1. WAIT=0. Store word 32'h1122_3344 at 32'h1000, then load word at 32'h1000, issued on consecutive cycles.
   - Expect READY on each of two consecutive cycles.
   - Expect RD=32'h1122_3344 on the load; BUSY stays 0.
2. Starting from scenario 1's contents:
   - sb 8'hAB at 32'h1001, then lw 32'h1000: expect RD=32'h11AB_3344.
   - lb 32'h1001: expect RD=32'hFFFF_FFAB.
   - lbu 32'h1001: expect RD=32'h0000_00AB.
   - lh 32'h1002: expect RD=32'h0000_3344.
3. WAIT=3. Load from 32'h007F_FFFC after storing 32'hCAFE_F00D there.
   - Expect BUSY=1 for 3 cycles, then READY for 1 cycle with RD=32'hCAFE_F00D.
   - REQ driven during BUSY must be ignored.
4. Faults:
   - lw 32'h1002: expect FAULT=01, RD=0.
   - sw 32'h0040_0000: expect FAULT=10, no write.
   - lh 32'h0050_0001: expect FAULT=11.
5. WAIT=3. Drop RST_N during WAITING of a store to 32'h1004.
   - Expect BUSY and READY to go to 0 immediately.
   - A later lw 32'h1004 returns the old contents.
6. With MEM_TEXT_WP_EN defined: sw 32'h0000_0010 gives FAULT=10, and a following lw shows the old value. Without the macro, the same store succeeds.

Source files
------------

// File: rtl/mem_regions.sv
// Purpose : region-mapped data memory (text/data/stack) for the MEM stage; byte/half/word, big-endian lanes.
// Latency : access at edge k+WAIT for a request accepted at edge k; READY pulses the cycle after.
// Backpr. : BUSY=1 while waiting; REQ ignored while BUSY. Back-to-back accepted from DONE.
//
// Optional feature macro: MEM_TEXT_WP_EN (defined = text region write-protected).
//
// Ports:
//   CLK, RST_N      clock (rising) and asynchronous active-low reset
//   REQ, WE         request strobe; 1 = store, 0 = load
//   SIZE, UNS       00 byte, 01 half, 1x word; UNS = zero-extend loads
//   A, WD           byte address, right-justified store data
//   BUSY, READY     wait-state indicator, one-cycle completion pulse
//   RD, FAULT       load data (extended), {access fault, misaligned}
module mem_regions #(
    parameter logic [31:0] TEXT_BASE   = 32'h0000_0000,
    parameter int          TEXT_WORDS  = 256,
    parameter logic [31:0] DATA_BASE   = 32'h0000_1000,
    parameter int          DATA_WORDS  = 256,
    parameter logic [31:0] STACK_TOP   = 32'h007F_FFFC,
    parameter int          STACK_WORDS = 256,
    parameter int          WAIT        = 0
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        REQ,
    input  logic        WE,
    input  logic [1:0]  SIZE,
    input  logic        UNS,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic        BUSY,
    output logic        READY,
    output logic [31:0] RD,
    output logic [1:0]  FAULT
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAITING = 2'd1;
    localparam logic [1:0] S_DONE    = 2'd2;

    localparam int TIW = (TEXT_WORDS  > 1) ? $clog2(TEXT_WORDS)  : 1;
    localparam int DIW = (DATA_WORDS  > 1) ? $clog2(DATA_WORDS)  : 1;
    localparam int SIW = (STACK_WORDS > 1) ? $clog2(STACK_WORDS) : 1;

    localparam logic [31:0] TEXT_SPAN  = 32'(4 * TEXT_WORDS);
    localparam logic [31:0] DATA_SPAN  = 32'(4 * DATA_WORDS);
    localparam logic [31:0] STACK_SPAN = 32'(4 * STACK_WORDS);
    // Stack grows down from STACK_TOP; its lowest word anchors the index.
    localparam logic [31:0] STACK_LO   = STACK_TOP - 32'(4 * (STACK_WORDS - 1));
    localparam logic [3:0]  WAIT_CNT   = 4'(WAIT);

`ifdef MEM_TEXT_WP_EN
    localparam logic TEXT_WP = 1'b1;
`else
    localparam logic TEXT_WP = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [1:0]  state_q;
    logic [3:0]  cnt_q;
    logic [31:0] a_q;
    logic [31:0] wd_q;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;

    logic accept;
    logic finish_wait;
    logic do_access;

    assign BUSY  = (state_q == S_WAITING);
    assign READY = (state_q == S_DONE);

    assign accept      = REQ & ~BUSY;
    assign finish_wait = (state_q == S_WAITING) && (cnt_q <= 4'd1);
    // With no wait states the access happens on the accepting edge itself.
    assign do_access   = (accept && (WAIT_CNT == 4'd0)) || finish_wait;

    // Operands: live inputs when the access coincides with acceptance,
    // otherwise the copy latched at acceptance.
    logic        use_live;
    logic [31:0] op_a;
    logic [31:0] op_wd;
    logic        op_we;
    logic [1:0]  op_size;
    logic        op_uns;

    assign use_live = (state_q != S_WAITING);
    assign op_a     = use_live ? A    : a_q;
    assign op_wd    = use_live ? WD   : wd_q;
    assign op_we    = use_live ? WE   : we_q;
    assign op_size  = use_live ? SIZE : size_q;
    assign op_uns   = use_live ? UNS  : uns_q;

    // ------------------------------------------------------------------
    // Region decode: 33-bit subtraction, bit 32 set means below the base
    // ------------------------------------------------------------------
    logic [32:0] text_diff;
    logic [32:0] data_diff;
    logic [32:0] stack_diff;
    logic        text_hit;
    logic        data_hit;
    logic        stack_hit;
    logic        sel_text;
    logic        sel_data;
    logic        sel_stack;
    logic        mapped;

    assign text_diff  = {1'b0, op_a} - {1'b0, TEXT_BASE};
    assign data_diff  = {1'b0, op_a} - {1'b0, DATA_BASE};
    assign stack_diff = {1'b0, op_a} - {1'b0, STACK_LO};

    assign text_hit  = ~text_diff[32]  && (text_diff[31:0]  < TEXT_SPAN);
    assign data_hit  = ~data_diff[32]  && (data_diff[31:0]  < DATA_SPAN);
    assign stack_hit = ~stack_diff[32] && (stack_diff[31:0] < STACK_SPAN);

    // Overlap resolution: stack wins over data, data over text.
    assign sel_stack = stack_hit;
    assign sel_data  = data_hit & ~stack_hit;
    assign sel_text  = text_hit & ~data_hit & ~stack_hit;
    assign mapped    = sel_stack | sel_data | sel_text;

    logic [TIW-1:0] t_idx;
    logic [DIW-1:0] d_idx;
    logic [SIW-1:0] s_idx;

    assign t_idx = text_diff[TIW+1:2];
    assign d_idx = data_diff[DIW+1:2];
    assign s_idx = stack_diff[SIW+1:2];

    // ------------------------------------------------------------------
    // Storage (not reset)
    // ------------------------------------------------------------------
    logic [31:0] text_mem  [TEXT_WORDS];
    logic [31:0] data_mem  [DATA_WORDS];
    logic [31:0] stack_mem [STACK_WORDS];

    logic [31:0] old_word;

    always_comb begin
        old_word = '0;
        if (sel_stack) begin
            old_word = stack_mem[s_idx];
        end else if (sel_data) begin
            old_word = data_mem[d_idx];
        end else if (sel_text) begin
            old_word = text_mem[t_idx];
        end
    end

    // ------------------------------------------------------------------
    // Faults
    // ------------------------------------------------------------------
    logic       misalign;
    logic       acc_fault;
    logic [1:0] fault_vec;

    always_comb begin
        misalign = 1'b0;
        case (op_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = op_a[0];
            default: misalign = (op_a[1:0] != 2'b00);
        endcase
    end

    assign acc_fault = ~mapped | (TEXT_WP & op_we & sel_text);
    assign fault_vec = {acc_fault, misalign};

    // ------------------------------------------------------------------
    // Byte lanes, big-endian: A[1:0]=0 is bits 31:24, so shift = (3-A)*8
    // ------------------------------------------------------------------
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] ld_val;
    logic [31:0] rd_next;

    assign byte_sh = {~op_a[1:0], 3'b000};
    assign half_sh = op_a[1] ? 5'd0 : 5'd16;
    assign byte_v  = 8'(old_word >> byte_sh);
    assign half_v  = 16'(old_word >> half_sh);

    always_comb begin
        ld_val = old_word;
        case (op_size)
            2'b00:   ld_val = op_uns ? {24'b0, byte_v} : {{24{byte_v[7]}}, byte_v};
            2'b01:   ld_val = op_uns ? {16'b0, half_v} : {{16{half_v[15]}}, half_v};
            default: ld_val = old_word;
        endcase
    end

    // Stores and faulted accesses return zero rather than stale data.
    assign rd_next = (op_we || (fault_vec != 2'b00)) ? 32'b0 : ld_val;

    // ------------------------------------------------------------------
    // Store merge
    // ------------------------------------------------------------------
    logic [31:0] st_mask;
    logic [31:0] st_data;
    logic [31:0] new_word;
    logic        wr_en;

    always_comb begin
        st_mask = 32'hFFFF_FFFF;
        st_data = op_wd;
        case (op_size)
            2'b00: begin
                st_mask = 32'h0000_00FF << byte_sh;
                st_data = {24'b0, op_wd[7:0]} << byte_sh;
            end
            2'b01: begin
                st_mask = 32'h0000_FFFF << half_sh;
                st_data = {16'b0, op_wd[15:0]} << half_sh;
            end
            default: begin
                st_mask = 32'hFFFF_FFFF;
                st_data = op_wd;
            end
        endcase
    end

    assign new_word = (old_word & ~st_mask) | (st_data & st_mask);

    // RST_N gates the write so a request held across reset cannot commit.
    assign wr_en = do_access & RST_N & op_we & (fault_vec == 2'b00);

    always_ff @(posedge CLK) begin
        if (wr_en && sel_text) begin
            text_mem[t_idx] <= new_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en && sel_data) begin
            data_mem[d_idx] <= new_word;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en && sel_stack) begin
            stack_mem[s_idx] <= new_word;
        end
    end

    // ------------------------------------------------------------------
    // FSM, operand latch, result registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'b0;
            wd_q    <= 32'b0;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            RD      <= 32'b0;
            FAULT   <= 2'b00;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        a_q    <= A;
                        wd_q   <= WD;
                        we_q   <= WE;
                        size_q <= SIZE;
                        uns_q  <= UNS;
                        if (WAIT_CNT == 4'd0) begin
                            state_q <= S_DONE;
                        end else begin
                            state_q <= S_WAITING;
                            cnt_q   <= WAIT_CNT;
                        end
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_WAITING: begin
                    // The counter reaching zero coincides with the access edge.
                    if (cnt_q <= 4'd1) begin
                        state_q <= S_DONE;
                        cnt_q   <= 4'd0;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase

            if (do_access) begin
                RD    <= rd_next;
                FAULT <= fault_vec;
            end
        end
    end

    // Offset bits outside the word index are consumed here on purpose.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{text_diff[32:TIW+2], text_diff[1:0],
                                  data_diff[32:DIW+2], data_diff[1:0],
                                  stack_diff[32:SIW+2], stack_diff[1:0]};

endmodule
